// File: rtl/int_alu_issue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | int_alu_issue                                                               |
// | Two-stage issue front end for an external registered 64-bit integer adder:  |
// | op decode (S1), tag carry while the adder computes (S2), credit-guarded FIFO|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

module int_alu_issue #(
   parameter int TAG_W = 4,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [2:0]       i_req_op,
   input  logic             i_req_rv32,
   input  logic [63:0]      i_req_a1,
   input  logic [63:0]      i_req_a2,
   input  logic [TAG_W-1:0] i_req_tag,
   output logic [6:0]       o_mode,
   output logic [63:0]      o_a1,
   output logic [63:0]      o_a2,
   input  logic [63:0]      i_res,
   output logic             o_resp_valid,
   input  logic             i_resp_ready,
   output logic [63:0]      o_resp_res,
   output logic [TAG_W-1:0] o_resp_tag
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_SLT  = 3'd2;
   localparam logic [2:0] OP_SLTU = 3'd3;
   localparam logic [2:0] OP_MIN  = 3'd4;
   localparam logic [2:0] OP_MINU = 3'd5;
   localparam logic [2:0] OP_MAX  = 3'd6;
   localparam logic [2:0] OP_MAXU = 3'd7;

   logic             accept;
   logic [6:0]       mode_dec;

   logic             s1_valid;
   logic [6:0]       s1_mode;
   logic [63:0]      s1_a1;
   logic [63:0]      s1_a2;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_valid;
   logic [TAG_W-1:0] s2_tag;

   logic [63:0]      res_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_wr;
   logic             fifo_rd;
   logic [CNT_W:0]   credit_used;

   // Every accepted request owns a FIFO slot from acceptance onward, so the
   // FIFO can never be asked to take more than it holds.
   assign credit_used = {1'b0, fifo_count}
                      + {{CNT_W{1'b0}}, s1_valid}
                      + {{CNT_W{1'b0}}, s2_valid};
   assign o_req_ready = ~i_rst & ~i_flush & (credit_used < (CNT_W+1)'(DEPTH));
   assign accept      = i_req_valid & o_req_ready;

   always_comb begin
      mode_dec    = 7'd0;
      mode_dec[0] = i_req_rv32;
      case (i_req_op)
         OP_ADD:  mode_dec[2] = 1'b1;
         OP_SUB:  mode_dec[3] = 1'b1;
         OP_SLT:  mode_dec[4] = 1'b1;
         OP_SLTU: begin mode_dec[4] = 1'b1; mode_dec[1] = 1'b1; end
         OP_MIN:  mode_dec[5] = 1'b1;
         OP_MINU: begin mode_dec[5] = 1'b1; mode_dec[1] = 1'b1; end
         OP_MAX:  mode_dec[6] = 1'b1;
         OP_MAXU: begin mode_dec[6] = 1'b1; mode_dec[1] = 1'b1; end
         default: mode_dec = 7'd0;
      endcase
   end

   // S1: adder operands are driven straight from these registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_mode  <= 7'd0;
         s1_a1    <= 64'd0;
         s1_a2    <= 64'd0;
         s1_tag   <= '0;
      end else if (i_flush) begin
         s1_valid <= 1'b0;
         s1_mode  <= 7'd0;
         s1_a1    <= 64'd0;
         s1_a2    <= 64'd0;
         s1_tag   <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_mode <= mode_dec;
            s1_a1   <= i_req_a1;
            s1_a2   <= i_req_a2;
            s1_tag  <= i_req_tag;
         end else begin
            s1_mode <= 7'd0;
            s1_a1   <= 64'd0;
            s1_a2   <= 64'd0;
         end
      end
   end

   assign o_mode = s1_mode;
   assign o_a1   = s1_a1;
   assign o_a2   = s1_a2;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid <= 1'b0;
         s2_tag   <= '0;
      end else if (i_flush) begin
         s2_valid <= 1'b0;
         s2_tag   <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_tag   <= s1_tag;
      end
   end

   assign fifo_full = (fifo_count == CNT_W'(DEPTH));
   assign fifo_rd   = o_resp_valid & i_resp_ready;
   assign fifo_wr   = s2_valid & ~i_flush & (~fifo_full | fifo_rd);

   // Storage needs no reset: contents are only visible while counted valid
   always_ff @(posedge i_clk) begin
      if (fifo_wr) begin
         res_mem[wr_ptr] <= i_res;
         tag_mem[wr_ptr] <= s2_tag;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (i_flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (fifo_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({fifo_wr, fifo_rd})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign o_resp_valid = (fifo_count != '0);
   assign o_resp_res   = o_resp_valid ? res_mem[rd_ptr] : 64'd0;
   assign o_resp_tag   = o_resp_valid ? tag_mem[rd_ptr] : '0;

endmodule

`default_nettype wire
